// File: rtl/seg_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan driver.
package seg_pkg;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      DRIVE = 2'd1,
      GUARD = 2'd2
   } scan_state_e;

   localparam int SEG_NIBBLE_W   = 4;
   localparam int SEG_MAX_DIGITS = 8;

   function automatic logic [SEG_MAX_DIGITS-1:0] sel_onehot(input logic [2:0] idx,
                                                            input logic       active_low);
      logic [SEG_MAX_DIGITS-1:0] hot;
      hot = 8'b0000_0001 << idx;
      if (active_low) begin
         return ~hot;
      end else begin
         return hot;
      end
   endfunction

   function automatic logic [SEG_MAX_DIGITS-1:0] sel_none(input logic active_low);
      if (active_low) begin
         return 8'hFF;
      end else begin
         return 8'h00;
      end
   endfunction

endpackage

// File: rtl/seg_scan_mux_slot_timer.sv
// Slot counter for the scan driver: registered pulses mark the last drive
// cycle and the last guard cycle of every slot.
module seg_slot_timer #(
   parameter int DIV          = 10,
   parameter int GUARD_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic drive_end,
   output logic guard_end
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DIV - GUARD_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;

   // next count: wrap at slot end, forced to zero by the clear input
   always_comb begin
      if (clear) begin
         cnt_s = {CNT_W{1'b0}};
      end else if (cnt_r == SLOT_LAST) begin
         cnt_s = {CNT_W{1'b0}};
      end else begin
         cnt_s = cnt_r + CNT_W'(1);
      end
   end

   // pulses are decoded from the next count so they line up with cnt_r
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r     <= {CNT_W{1'b0}};
         drive_end <= 1'b0;
         guard_end <= 1'b0;
      end else begin
         cnt_r     <= cnt_s;
         drive_end <= (cnt_s == DRIVE_LAST);
         guard_end <= (cnt_s == SLOT_LAST);
      end
   end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scan driver with frame-synchronous double buffering.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg_scan_mux
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int CLK_HZ         = 50_000_000,
   parameter int SCAN_HZ        = 1000,
   parameter int GUARD_CYCLES   = 16,
   parameter int SEL_ACTIVE_LOW = 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 en,
   input  logic                                 load,
   input  logic [SEG_NIBBLE_W*NUM_DIGITS-1:0]   value,
   input  logic [NUM_DIGITS-1:0]                blank_mask,
   output logic [SEG_NIBBLE_W-1:0]              digit_nibble,
   output logic [NUM_DIGITS-1:0]                digit_sel,
   output logic [$clog2(NUM_DIGITS)-1:0]        digit_idx,
   output logic                                 frame_done
);

   localparam int   DIV      = CLK_HZ / SCAN_HZ;
   localparam int   IDX_W    = $clog2(NUM_DIGITS);
   localparam int   VAL_W    = SEG_NIBBLE_W * NUM_DIGITS;
   localparam logic SEL_AL   = (SEL_ACTIVE_LOW != 0);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   scan_state_e             state_r;
   scan_state_e             state_s;
   logic [IDX_W-1:0]        idx_s;
   logic                    wrap_s;
   logic                    frame_s;
   logic [VAL_W-1:0]        act_val_r, act_val_s, pend_val_r, pend_val_s;
   logic [NUM_DIGITS-1:0]   act_blank_r, act_blank_s, pend_blank_r, pend_blank_s;
   logic                    pend_flag_r, pend_flag_s;
   logic [NUM_DIGITS-1:0]   eff_blank_s;
   logic [NUM_DIGITS-1:0]   sel_hot_s;
   logic [NUM_DIGITS-1:0]   sel_idle_s;
   logic [SEG_NIBBLE_W-1:0] nibble_s;
   logic                    timer_clear_s;
   logic                    drive_end;
   logic                    guard_end;
`ifdef LEADING_ZERO_BLANK_EN
   logic                    upper_zero_s;
`endif

   assign timer_clear_s = (!en) || (state_r == OFF);

   seg_slot_timer #(
      .DIV          (DIV),
      .GUARD_CYCLES (GUARD_CYCLES)
   ) u_slot_timer (
      .clk       (clk),
      .rst       (rst),
      .clear     (timer_clear_s),
      .drive_end (drive_end),
      .guard_end (guard_end)
   );

   // scan sequencing; wrap_s marks edges where a new frame starts
   always_comb begin
      state_s = state_r;
      idx_s   = digit_idx;
      wrap_s  = 1'b0;
      frame_s = 1'b0;
      if (!en) begin
         state_s = OFF;
         idx_s   = {IDX_W{1'b0}};
      end else begin
         case (state_r)
            OFF: begin
               state_s = DRIVE;
               idx_s   = {IDX_W{1'b0}};
               wrap_s  = 1'b1;
            end
            DRIVE: begin
               if (drive_end) begin
                  state_s = GUARD;
               end else begin
                  state_s = DRIVE;
               end
            end
            GUARD: begin
               if (guard_end) begin
                  state_s = DRIVE;
                  if (digit_idx == LAST_IDX) begin
                     idx_s   = {IDX_W{1'b0}};
                     wrap_s  = 1'b1;
                     frame_s = 1'b1;
                  end else begin
                     idx_s = digit_idx + IDX_W'(1);
                  end
               end else begin
                  state_s = GUARD;
               end
            end
            default: begin
               state_s = OFF;
               idx_s   = {IDX_W{1'b0}};
            end
         endcase
      end
   end

   // double buffer: data reaches the active copy only at a frame start
   always_comb begin
      act_val_s    = act_val_r;
      act_blank_s  = act_blank_r;
      pend_val_s   = pend_val_r;
      pend_blank_s = pend_blank_r;
      pend_flag_s  = pend_flag_r;
      if (wrap_s && load) begin
         act_val_s   = value;
         act_blank_s = blank_mask;
         pend_flag_s = 1'b0;
      end else if (wrap_s && pend_flag_r) begin
         act_val_s   = pend_val_r;
         act_blank_s = pend_blank_r;
         pend_flag_s = 1'b0;
      end else if (load) begin
         pend_val_s   = value;
         pend_blank_s = blank_mask;
         pend_flag_s  = 1'b1;
      end else begin
         pend_flag_s = pend_flag_r;
      end
   end

   // effective blanking, scanned from the most significant digit down
   always_comb begin
      eff_blank_s = act_blank_s;
`ifdef LEADING_ZERO_BLANK_EN
      upper_zero_s = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         upper_zero_s = upper_zero_s && (act_val_s[SEG_NIBBLE_W*i +: SEG_NIBBLE_W] == 4'h0);
         if (upper_zero_s && (i != 0)) begin
            eff_blank_s[i] = 1'b1;
         end else begin
            eff_blank_s[i] = act_blank_s[i];
         end
      end
`endif
   end

   // nibble and enable for the digit that will be driven after this edge
   always_comb begin
      nibble_s = 4'h0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (IDX_W'(i) == idx_s) begin
            nibble_s = act_val_s[SEG_NIBBLE_W*i +: SEG_NIBBLE_W];
         end else begin
            nibble_s = nibble_s;
         end
      end
      sel_hot_s  = NUM_DIGITS'(sel_onehot(3'(idx_s), SEL_AL));
      sel_idle_s = NUM_DIGITS'(sel_none(SEL_AL));
   end

   // state, buffers and all outputs share one edge so nibble and anode stay aligned
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= OFF;
         digit_idx    <= {IDX_W{1'b0}};
         digit_nibble <= 4'h0;
         digit_sel    <= sel_idle_s;
         frame_done   <= 1'b0;
         act_val_r    <= {VAL_W{1'b0}};
         act_blank_r  <= {NUM_DIGITS{1'b0}};
         pend_val_r   <= {VAL_W{1'b0}};
         pend_blank_r <= {NUM_DIGITS{1'b0}};
         pend_flag_r  <= 1'b0;
      end else begin
         state_r      <= state_s;
         digit_idx    <= idx_s;
         frame_done   <= frame_s;
         act_val_r    <= act_val_s;
         act_blank_r  <= act_blank_s;
         pend_val_r   <= pend_val_s;
         pend_blank_r <= pend_blank_s;
         pend_flag_r  <= pend_flag_s;
         if (state_s == DRIVE) begin
            digit_nibble <= nibble_s;
            if (eff_blank_s[idx_s]) begin
               digit_sel <= sel_idle_s;
            end else begin
               digit_sel <= sel_hot_s;
            end
         end else begin
            digit_nibble <= digit_nibble;
            digit_sel    <= sel_idle_s;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: directed scenarios plus random loads,
// compared against a time-arithmetic model of the scan sequence.
module tb_seg_scan_mux;

   localparam int N     = 4;
   localparam int DIV   = 10;
   localparam int G     = 2;
   localparam int FRAME = N * DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        load = 1'b0;
   logic [15:0] value = 16'h0;
   logic [3:0]  blank_mask = 4'h0;
   logic [3:0]  digit_nibble;
   logic [3:0]  digit_sel;
   logic [1:0]  digit_idx;
   logic        frame_done;

   int tests = 0;
   int failed = 0;

   // model: m_t counts cycles since the display started driving
   bit          m_on;
   int          m_t;
   logic [15:0] m_act, m_pend;
   logic [3:0]  m_actb, m_pendb;
   bit          m_pflag;
   logic [3:0]  m_nib;
   bit          m_nib_known;
   bit          m_fd;

   seg_scan_mux #(
      .NUM_DIGITS     (N),
      .CLK_HZ         (100),
      .SCAN_HZ        (10),
      .GUARD_CYCLES   (G),
      .SEL_ACTIVE_LOW (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .load         (load),
      .value        (value),
      .blank_mask   (blank_mask),
      .digit_nibble (digit_nibble),
      .digit_sel    (digit_sel),
      .digit_idx    (digit_idx),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   function automatic bit m_blank(int d);
      bit b;
      b = m_actb[d];
`ifdef LEADING_ZERO_BLANK_EN
      if (d != 0 && (m_act >> (4 * d)) == 16'h0) b = 1'b1;
`endif
      return b;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      bit   boundary;
      int   slot;
      bit   lit;
      logic [3:0] exp_sel;
      @(posedge clk);
      boundary = 1'b0;
      m_fd     = 1'b0;
      if (rst) begin
         m_on = 1'b0; m_t = 0; m_act = 16'h0; m_actb = 4'h0;
         m_pend = 16'h0; m_pendb = 4'h0; m_pflag = 1'b0;
         m_nib = 4'h0; m_nib_known = 1'b1;
      end else begin
         if (!en) begin
            m_on = 1'b0; m_t = 0; m_nib_known = 1'b0;
         end else if (!m_on) begin
            m_on = 1'b1; m_t = 0; boundary = 1'b1;
         end else begin
            m_t++;
            if (m_t % FRAME == 0) begin
               boundary = 1'b1;
               m_fd = 1'b1;
            end
         end
         if (boundary && load) begin
            m_act = value; m_actb = blank_mask; m_pflag = 1'b0;
         end else if (boundary && m_pflag) begin
            m_act = m_pend; m_actb = m_pendb; m_pflag = 1'b0;
         end else if (load) begin
            m_pend = value; m_pendb = blank_mask; m_pflag = 1'b1;
         end
      end
      #1;
      slot = (m_t / DIV) % N;
      lit  = m_on && ((m_t % DIV) < (DIV - G));
      if (lit) begin
         m_nib = 4'(m_act >> (4 * slot));
         m_nib_known = 1'b1;
      end
      exp_sel = (lit && !m_blank(slot)) ? 4'(~(4'b0001 << slot)) : 4'b1111;
      check("digit_sel", 32'(digit_sel), 32'(exp_sel));
      check("digit_idx", 32'(digit_idx), m_on ? slot : 0);
      check("frame_done", 32'(frame_done), 32'(m_fd));
      if (m_nib_known) check("digit_nibble", 32'(digit_nibble), 32'(m_nib));
   endtask

   task automatic run(int n);
      repeat (n) tick();
   endtask

   task automatic pulse_load(logic [15:0] v, logic [3:0] b);
      value = v; blank_mask = b; load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic wait_pos(int p);
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 200 && !hit; k++) begin
         if (m_on && (m_t % FRAME) == p) hit = 1'b1;
         else tick();
      end
      tests++;
      assert (hit) else begin
         failed++;
         $error("FAIL wait_pos observed=timeout expected=position %0d", p);
      end
   endtask

   initial begin
      // reset values
      rst = 1'b1;
      run(2);
      rst = 1'b0;
      // 1: start with 1234 loaded on the OFF->DRIVE edge
      en = 1'b1;
      pulse_load(16'h1234, 4'b0000);
      run(85);
      // 2: mid-frame load shows only from the next frame
      wait_pos(15);
      pulse_load(16'hABCD, 4'b0000);
      run(70);
      // 3: load on the wrap edge goes straight to active, next load waits
      wait_pos(39);
      pulse_load(16'h00FF, 4'b0000);
      pulse_load(16'h5555, 4'b0000);
      run(90);
      // 4: blank mask
      pulse_load(16'h9876, 4'b0101);
      run(90);
      // 5: enable drop in slot 2, then reset mid-drive
      wait_pos(23);
      en = 1'b0;
      run(5);
      en = 1'b1;
      run(50);
      wait_pos(13);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      run(45);
`ifdef LEADING_ZERO_BLANK_EN
      // 6: leading zero blanking
      pulse_load(16'h0042, 4'b0000);
      run(85);
      pulse_load(16'h0000, 4'b0000);
      run(85);
`endif
      // random loads, blanks and enable drops
      for (int r = 0; r < 30; r++) begin
         value      = 16'($urandom);
         blank_mask = (r % 3 == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         load = 1'b1;
         tick();
         load = 1'b0;
         run($urandom_range(1, 60));
         if ($urandom_range(0, 7) == 0) begin
            en = 1'b0;
            run($urandom_range(1, 4));
            en = 1'b1;
         end
      end
      run(100);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
